region_blitter: RTL and testbench

// - Parametrised successor to the full-screen background painter: copies a rectangular image (W x H) from one of
//   NUM_SOURCES synchronous ROMs to any origin on screen, and clips pixels that fall off the screen.
// - Sits between the game-control FSM (start/done handshake) and the VGA adapter plot port (plotX/plotY/plotColour/plotEnable).
// - Used for full-screen backgrounds (origin 0,0, size = screen) and for sprites (lander, pads, text).

---
 rtl/region_blitter_if.sv | 39 +++
 rtl/region_blitter.sv | 184 ++++++++++++++++++
 tb/tb_region_blitter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/region_blitter_if.sv
// Control, ROM and plot bundle for region_blitter.
// master = game FSM + ROM bank side, slave = the blitter.
interface region_blitter_if #(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int NUM_SOURCES = 5,
    parameter int SEL_BITS    = 3,
    parameter int ADDR_BITS   = 15
);
    logic                               start;
    logic [SEL_BITS-1:0]                sourceSelect;
    logic [X_BITS-1:0]                  originX;
    logic [Y_BITS-1:0]                  originY;
    logic [X_BITS-1:0]                  width;
    logic [Y_BITS-1:0]                  height;
    logic [ADDR_BITS-1:0]               romAddress;
    logic [NUM_SOURCES*COLOUR_BITS-1:0] romData;
    logic [X_BITS-1:0]                  plotX;
    logic [Y_BITS-1:0]                  plotY;
    logic [COLOUR_BITS-1:0]             plotColour;
    logic                               plotEnable;
    logic                               busy;
    logic                               done;

    modport master (
        output start, sourceSelect, originX, originY,
        output width, height, romData,
        input  romAddress, plotX, plotY, plotColour,
        input  plotEnable, busy, done
    );

    modport slave (
        input  start, sourceSelect, originX, originY,
        input  width, height, romData,
        output romAddress, plotX, plotY, plotColour,
        output plotEnable, busy, done
    );
endinterface

// File: rtl/region_blitter.sv
// Copies a WxH image from one of several ROMs to any screen origin, clipping off-screen pixels.
// Define BLIT_TRANSPARENCY_EN to suppress pixels whose colour equals TRANSPARENT_COLOUR.
module region_blitter #(
    parameter int X_SCREEN_PIXELS    = 160,
    parameter int Y_SCREEN_PIXELS    = 120,
    parameter int X_BITS             = 8,
    parameter int Y_BITS             = 7,
    parameter int COLOUR_BITS        = 3,
    parameter int NUM_SOURCES        = 5,
    parameter int SEL_BITS           = 3,
    parameter int ADDR_BITS          = 15,
    parameter int ROM_LATENCY        = 1,
    parameter int TRANSPARENT_COLOUR = 0
) (
    input logic             Clock,
    input logic             Reset,
    region_blitter_if.slave blit
);
    localparam int CNT_BITS = $clog2(ROM_LATENCY + 2);
    localparam logic [COLOUR_BITS-1:0] KEY = COLOUR_BITS'(TRANSPARENT_COLOUR);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } stateType;

    stateType             state;
    logic [SEL_BITS-1:0]  selReg;
    logic [X_BITS-1:0]    oxReg;
    logic [Y_BITS-1:0]    oyReg;
    logic [X_BITS-1:0]    wReg;
    logic [Y_BITS-1:0]    hReg;
    logic [X_BITS-1:0]    col;
    logic [Y_BITS-1:0]    row;
    logic [ADDR_BITS-1:0] addr;
    logic [CNT_BITS-1:0]  drainCnt;
    logic                 busyReg;
    logic                 doneReg;

    logic [X_BITS:0]      xPos;
    logic [Y_BITS:0]      yPos;
    logic                 onScreen;
    logic                 lastCol;
    logic                 lastRow;

    // Wide sums so an origin near the edge cannot wrap back on screen.
    assign xPos = {1'b0, oxReg} + {1'b0, col};
    assign yPos = {1'b0, oyReg} + {1'b0, row};
    assign onScreen = (xPos < (X_BITS+1)'(X_SCREEN_PIXELS))
                   && (yPos < (Y_BITS+1)'(Y_SCREEN_PIXELS));
    assign lastCol = (col == wReg - 1'b1);
    assign lastRow = (row == hReg - 1'b1);

    assign blit.romAddress = addr;
    assign blit.busy       = busyReg;
    assign blit.done       = doneReg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            selReg   <= '0;
            oxReg    <= '0;
            oyReg    <= '0;
            wReg     <= '0;
            hReg     <= '0;
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            drainCnt <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (blit.start) begin
                        selReg <= blit.sourceSelect;
                        oxReg  <= blit.originX;
                        oyReg  <= blit.originY;
                        wReg   <= blit.width;
                        hReg   <= blit.height;
                        col    <= '0;
                        row    <= '0;
                        addr   <= '0;
                        if (blit.width == '0 || blit.height == '0) begin
                            state   <= DONE;
                            doneReg <= 1'b1;
                        end else begin
                            state   <= SCAN;
                            busyReg <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    addr <= addr + 1'b1;
                    if (lastCol) begin
                        col <= '0;
                        if (lastRow) begin
                            state    <= DRAIN;
                            drainCnt <= '0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drainCnt == CNT_BITS'(ROM_LATENCY)) begin
                        state   <= DONE;
                        busyReg <= 1'b0;
                        doneReg <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [COLOUR_BITS-1:0] srcColour;
    logic                   keyEnable;
    logic                   keyed;

    always_comb begin
        srcColour = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (selReg == SEL_BITS'(i)) begin
                srcColour = blit.romData[i*COLOUR_BITS +: COLOUR_BITS];
            end
        end
    end

`ifdef BLIT_TRANSPARENCY_EN
    assign keyEnable = 1'b1;
`else
    assign keyEnable = 1'b0;
`endif
    assign keyed = keyEnable && (srcColour == KEY);

    logic              pipeValid [ROM_LATENCY];
    logic [X_BITS-1:0] pipeX     [ROM_LATENCY];
    logic [Y_BITS-1:0] pipeY     [ROM_LATENCY];

    // Coordinates travel alongside the ROM read so they meet romData.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipeValid[i] <= 1'b0;
                pipeX[i]     <= '0;
                pipeY[i]     <= '0;
            end
            blit.plotEnable <= 1'b0;
            blit.plotX      <= '0;
            blit.plotY      <= '0;
            blit.plotColour <= '0;
        end else begin
            pipeValid[0] <= (state == SCAN) && onScreen;
            pipeX[0]     <= xPos[X_BITS-1:0];
            pipeY[0]     <= yPos[Y_BITS-1:0];
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeX[i]     <= pipeX[i-1];
                pipeY[i]     <= pipeY[i-1];
            end
            if (pipeValid[ROM_LATENCY-1] && !keyed) begin
                blit.plotEnable <= 1'b1;
                blit.plotX      <= pipeX[ROM_LATENCY-1];
                blit.plotY      <= pipeY[ROM_LATENCY-1];
                blit.plotColour <= srcColour;
            end else begin
                blit.plotEnable <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_region_blitter.sv
// Randomised bench for region_blitter against a pixel-list reference model.
// Honours BLIT_TRANSPARENCY_EN the same way as the design.
module tb_region_blitter;
    localparam int NSRC  = 5;
    localparam int CB    = 3;
    localparam int DEPTH = 32768;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    always #5 Clock = ~Clock;

    region_blitter_if bus ();

    region_blitter dut (
        .Clock (Clock),
        .Reset (Reset),
        .blit  (bus)
    );

    logic [CB-1:0] rom [NSRC][DEPTH];

    always @(posedge Clock) begin
        for (int i = 0; i < NSRC; i++) begin
            bus.romData[i*CB +: CB] <= rom[i][bus.romAddress];
        end
    end

    int numChecks = 0;
    int numErrors = 0;

    logic [7:0] lastX = '0;
    logic [6:0] lastY = '0;
    logic [2:0] lastC = '0;

    task automatic checkValue(input string tag,
                              input logic [31:0] got,
                              input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetDut(input bit withStart);
        bus.start = withStart;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        bus.start = 1'b0;
        Reset = 1'b0;
        checkValue("rstAddr", 32'(bus.romAddress), 0);
        checkValue("rstPix", 32'({bus.plotX, bus.plotY, bus.plotColour}), 0);
        checkValue("rstEn", 32'(bus.plotEnable), 0);
        checkValue("rstBusy", 32'(bus.busy), 0);
        checkValue("rstDone", 32'(bus.done), 0);
        lastX = '0;
        lastY = '0;
        lastC = '0;
    endtask

    // Model: pixel k of the copy lands L+1+k cycles after the start edge.
    task automatic runBlit(input logic [2:0] sel, input logic [7:0] ox,
                           input logic [6:0] oy, input logic [7:0] w,
                           input logic [6:0] h, input bit midStart);
        int n;
        int doneOff;
        int last;
        bit expEn[];
        logic [17:0] expPix[];
        n = int'(w) * int'(h);
        doneOff = (n == 0) ? 0 : n + 2;
        last = doneOff + 3;
        expEn = new[last + 1];
        expPix = new[last + 1];
        for (int i = 0; i <= last; i++) begin
            expEn[i] = 1'b0;
            expPix[i] = '0;
        end
        for (int k = 0; k < n; k++) begin
            int x;
            int y;
            logic [2:0] c;
            bit plot;
            x = int'(ox) + k % int'(w);
            y = int'(oy) + k / int'(w);
            c = (sel < NSRC) ? rom[sel][k] : 3'd0;
            plot = (x < 160) && (y < 120);
`ifdef BLIT_TRANSPARENCY_EN
            if (c == 3'd0) plot = 1'b0;
`endif
            if (plot) begin
                expEn[k+2] = 1'b1;
                expPix[k+2] = {x[7:0], y[6:0], c};
            end
        end
        bus.sourceSelect = sel;
        bus.originX = ox;
        bus.originY = oy;
        bus.width = w;
        bus.height = h;
        bus.start = 1'b1;
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        for (int off = 0; off <= last; off++) begin
            if (expEn[off]) {lastX, lastY, lastC} = expPix[off];
            checkValue("plotEnable", 32'(bus.plotEnable), 32'(expEn[off]));
            checkValue("plotPixel",
                       32'({bus.plotX, bus.plotY, bus.plotColour}),
                       32'({lastX, lastY, lastC}));
            checkValue("done", 32'(bus.done), 32'(off == doneOff));
            checkValue("busy", 32'(bus.busy), 32'(off < doneOff));
            if (midStart && doneOff >= 4 && off == 2) begin
                bus.sourceSelect = 3'($urandom_range(0, 7));
                bus.originX = 8'($urandom_range(0, 255));
                bus.originY = 7'($urandom_range(0, 127));
                bus.width = 8'($urandom_range(0, 255));
                bus.height = 7'($urandom_range(0, 127));
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge Clock);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic resetMidScan;
        bus.sourceSelect = 3'd0;
        bus.originX = 8'd5;
        bus.originY = 7'd5;
        bus.width = 8'd20;
        bus.height = 7'd10;
        bus.start = 1'b1;
        @(posedge Clock);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge Clock);
        #1;
        checkValue("preRstEn", 32'(bus.plotEnable), 1);
        resetDut(1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock);
            #1;
            checkValue("postRstEn", 32'(bus.plotEnable), 0);
            checkValue("postRstBusy", 32'(bus.busy), 0);
            checkValue("postRstDone", 32'(bus.done), 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sourceSelect = '0;
        bus.originX = '0;
        bus.originY = '0;
        bus.width = '0;
        bus.height = '0;
        for (int a = 0; a < DEPTH; a++) begin
            for (int s = 0; s < NSRC; s++) begin
                rom[s][a] = 3'($urandom);
            end
            rom[1][a] = 3'(a % 8);
        end
        #1;
        resetDut(1'b0);

        runBlit(3'd1, 8'd0, 7'd0, 8'd160, 7'd120, 1'b0);
        runBlit(3'd1, 8'd10, 7'd20, 8'd4, 7'd2, 1'b0);
        runBlit(3'd1, 8'd158, 7'd118, 8'd4, 7'd4, 1'b0);
        runBlit(3'd2, 8'd0, 7'd0, 8'd0, 7'd5, 1'b0);
        runBlit(3'd2, 8'd3, 7'd3, 8'd3, 7'd0, 1'b0);
        runBlit(3'd6, 8'd40, 7'd40, 8'd3, 7'd3, 1'b0);
        runBlit(3'd3, 8'd50, 7'd60, 8'd8, 7'd5, 1'b1);

        rom[4][0] = 3'd0;
        rom[4][1] = 3'd5;
        runBlit(3'd4, 8'd30, 7'd30, 8'd2, 7'd1, 1'b0);

        resetMidScan();
        runBlit(3'd0, 8'd7, 7'd9, 8'd5, 7'd3, 1'b0);

        for (int t = 0; t < 30; t++) begin
            runBlit(3'($urandom_range(0, 7)), 8'($urandom_range(0, 170)),
                    7'($urandom_range(0, 127)), 8'($urandom_range(0, 24)),
                    7'($urandom_range(0, 16)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end
endmodule
